// File: rtl/rv32i_types.sv
// rv32i_types: shared hazard-controller FSM state and per-stage control types
package rv32i_types;

    typedef enum logic [1:0] {S_RESET, S_RUN, S_SQUASH} hazard_state_t;

    typedef struct packed {
        logic load;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating event counter, one increment per cycle inc is high
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc, stick at all-ones
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (inc && count != '1) count <= count + W'(1);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl
    import rv32i_types::*;
#(
    parameter  int NUM_REGS = 32,
    parameter  int PERF_W   = 32,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_resp,
    input  logic              dmem_resp,
    input  logic              mem_access,
    input  logic              id_valid,
    input  logic [RW-1:0]     id_src1,
    input  logic [RW-1:0]     id_src2,
    input  logic              ex_valid,
    input  logic [RW-1:0]     ex_dest,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    output logic              imem_read,
    output logic              pc_load,
    output logic              if_id_load,
    output logic              id_ex_load,
    output logic              ex_mem_load,
    output logic              mem_wb_load,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [PERF_W-1:0] perf_load_use,
    output logic [PERF_W-1:0] perf_mem_stall,
    output logic [PERF_W-1:0] perf_squash
);

    hazard_state_t state;
    stage_ctrl_t   if_id, id_ex;
    logic          mem_ok, load_use;

    assign mem_ok   = ~mem_access | dmem_resp;
    assign load_use = ex_valid & ex_mem_read & (ex_dest != '0) & id_valid &
                      (id_src1 == ex_dest | id_src2 == ex_dest);

    // stage enables; a redirect outranks load-use, a missing fetch holds the front end
    always_comb begin
        imem_read   = 1'b0;
        pc_load     = 1'b0;
        if_id       = '0;
        id_ex       = '0;
        ex_mem_load = 1'b0;
        mem_wb_load = 1'b0;
        if (state == S_RUN) begin
            imem_read = 1'b1;
            if (mem_ok) begin
                pc_load     = ex_redirect | (imem_resp & ~load_use);
                if_id.load  = imem_resp & (ex_redirect | ~load_use);
                if_id.flush = ex_redirect & imem_resp;
                id_ex.load  = 1'b1;
                id_ex.flush = ex_redirect | ~imem_resp | load_use;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
            end
        end else if (state == S_SQUASH) begin
            imem_read   = 1'b1;
            id_ex.load  = mem_ok;
            id_ex.flush = mem_ok;
            ex_mem_load = mem_ok;
            mem_wb_load = mem_ok;
        end
    end

    assign if_id_load  = if_id.load;
    assign if_id_flush = if_id.flush;
    assign id_ex_load  = id_ex.load;
    assign id_ex_flush = id_ex.flush;

    // holdoff after reset, then wait out stale fetches squashed by a redirect
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_RESET;
        else case (state)
            S_RESET:  state <= S_RUN;
            S_RUN:    state <= (mem_ok & ex_redirect & ~imem_resp) ? S_SQUASH : S_RUN;
            S_SQUASH: state <= imem_resp ? S_RUN : S_SQUASH;
            default:  state <= S_RESET;
        endcase

`ifdef HAZARD_PERF_CNT_EN
    logic inc_lu, inc_mem, inc_sq;

    assign inc_lu  = state == S_RUN & mem_ok & ~ex_redirect & imem_resp & load_use;
    assign inc_mem = state == S_RUN & ~mem_ok;
    assign inc_sq  = state == S_SQUASH;

    hazard_perf_cnt #(.W(PERF_W)) u_cnt_lu  (.clk(clk), .rst(rst), .inc(inc_lu),  .count(perf_load_use));
    hazard_perf_cnt #(.W(PERF_W)) u_cnt_mem (.clk(clk), .rst(rst), .inc(inc_mem), .count(perf_mem_stall));
    hazard_perf_cnt #(.W(PERF_W)) u_cnt_sq  (.clk(clk), .rst(rst), .inc(inc_sq),  .count(perf_squash));
`else
    assign perf_load_use  = '0;
    assign perf_mem_stall = '0;
    assign perf_squash    = '0;
`endif

endmodule
